// File: rtl/register_file.sv
`default_nettype none
//============================================================================
// Module      : register_file
// Description : 2^ADDRESS_WIDTH x DATA_WIDTH register file with two
//               combinational read ports, one write port, an accepted-write
//               counter and a one-request-at-a-time debug read port.
//               Entry 0 always reads as zero and ignores writes.
//
//   Optional feature (compile-time macro):
//     REGISTER_FILE_BYPASS_EN - a read of the address being written this
//                               cycle returns the incoming write data.
//
//   Ports:
//     clock, reset                  - rising-edge clock, async active-high reset
//     register_file_read_address_1/2, register_file_read_value_1/2
//                                   - zero-latency read ports
//     register_file_write_address/value/enable
//                                   - write port (address 0 is dropped)
//     debug_request, debug_address  - debug read request
//     debug_ack, debug_value        - one-cycle response pulse, held data
//     write_count                   - wrapping count of accepted writes
//
// Revision    : 1.0 - initial release
//============================================================================
module register_file #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] register_file_read_address_1,
    input  logic [ADDRESS_WIDTH-1:0] register_file_read_address_2,
    output logic [DATA_WIDTH-1:0]    register_file_read_value_1,
    output logic [DATA_WIDTH-1:0]    register_file_read_value_2,
    input  logic [ADDRESS_WIDTH-1:0] register_file_write_address,
    input  logic [DATA_WIDTH-1:0]    register_file_write_value,
    input  logic                     register_file_write_enable,
    input  logic                     debug_request,
    input  logic [ADDRESS_WIDTH-1:0] debug_address,
    output logic                     debug_ack,
    output logic [DATA_WIDTH-1:0]    debug_value,
    output logic [15:0]              write_count
);

    localparam int c_DEPTH = 1 << ADDRESS_WIDTH;

    localparam logic [0:0] c_STATE_IDLE    = 1'b0;
    localparam logic [0:0] c_STATE_RESPOND = 1'b1;

    logic [DATA_WIDTH-1:0] r_storage [c_DEPTH];
    logic [0:0]            r_state;
    logic [DATA_WIDTH-1:0] r_debug_value;
    logic [15:0]           r_write_count;

    logic w_write_accept;
    logic w_bypass_1;
    logic w_bypass_2;

    // Writes to entry 0 are discarded and not counted.
    assign w_write_accept = register_file_write_enable &&
                            (register_file_write_address != '0);

`ifdef REGISTER_FILE_BYPASS_EN
    assign w_bypass_1 = w_write_accept &&
                        (register_file_write_address == register_file_read_address_1);
    assign w_bypass_2 = w_write_accept &&
                        (register_file_write_address == register_file_read_address_2);
`else
    assign w_bypass_1 = 1'b0;
    assign w_bypass_2 = 1'b0;
`endif

    // Entry 0 is forced to zero at the read mux so the rule holds regardless
    // of what the storage array contains.
    assign register_file_read_value_1 =
        (register_file_read_address_1 == '0) ? '0 :
        w_bypass_1 ? register_file_write_value :
                     r_storage[register_file_read_address_1];

    assign register_file_read_value_2 =
        (register_file_read_address_2 == '0) ? '0 :
        w_bypass_2 ? register_file_write_value :
                     r_storage[register_file_read_address_2];

    // Storage array and accepted-write counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_storage[i] <= '0;
            end
            r_write_count <= 16'd0;
        end else if (w_write_accept) begin
            r_storage[register_file_write_address] <= register_file_write_value;
            r_write_count                          <= r_write_count + 16'd1;
        end
    end

    // Debug responder. The capture reads the storage array as it stands
    // before this edge, so a same-edge write to the same entry is not seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= c_STATE_IDLE;
            r_debug_value <= '0;
        end else begin
            case (r_state)
                c_STATE_IDLE: begin
                    if (debug_request) begin
                        r_debug_value <= (debug_address == '0) ? '0 :
                                         r_storage[debug_address];
                        r_state       <= c_STATE_RESPOND;
                    end
                end
                c_STATE_RESPOND: begin
                    // Requests arriving here are dropped; the requester retries.
                    r_state <= c_STATE_IDLE;
                end
                default: begin
                    r_state <= c_STATE_IDLE;
                end
            endcase
        end
    end

    assign debug_ack   = (r_state == c_STATE_RESPOND);
    assign debug_value = r_debug_value;
    assign write_count = r_write_count;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
//============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file. Directed scenarios
//               followed by randomized traffic, all compared against an
//               array-based reference model of the register file.
// Revision    : 1.0 - initial release
//============================================================================
module tb_register_file;

    logic        clock;
    logic        reset;
    logic [5:0]  ra1, ra2, waddr, daddr;
    logic [31:0] rv1, rv2, wval, dval;
    logic        we, dreq, dack;
    logic [15:0] wcount;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_mem [64];
    logic [15:0] m_count;
    logic        m_ack;
    logic [31:0] m_dval;

    register_file #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (6)
    ) dut (
        .clock                        (clock),
        .reset                        (reset),
        .register_file_read_address_1 (ra1),
        .register_file_read_address_2 (ra2),
        .register_file_read_value_1   (rv1),
        .register_file_read_value_2   (rv2),
        .register_file_write_address  (waddr),
        .register_file_write_value    (wval),
        .register_file_write_enable   (we),
        .debug_request                (dreq),
        .debug_address                (daddr),
        .debug_ack                    (dack),
        .debug_value                  (dval),
        .write_count                  (wcount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [5:0] a);
        if (a == 6'd0) return 32'd0;
`ifdef REGISTER_FILE_BYPASS_EN
        if (we && waddr != 6'd0 && waddr == a) return wval;
`endif
        return m_mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
        m_count = 16'd0;
        m_ack   = 1'b0;
        m_dval  = 32'd0;
    endtask

    // One clock cycle: check the read ports before the edge, advance the
    // model with the inputs presented, then check registered outputs.
    task automatic step(input bit chk);
        logic        acc, nack;
        logic [31:0] ndval;
        #1;
        if (chk) begin
            check_value("rd1", rv1, exp_read(ra1));
            check_value("rd2", rv2, exp_read(ra2));
        end
        acc   = we && (waddr != 6'd0);
        nack  = 1'b0;
        ndval = m_dval;
        if (!m_ack && dreq) begin
            nack  = 1'b1;
            ndval = (daddr == 6'd0) ? 32'd0 : m_mem[daddr];
        end
        @(posedge clock);
        m_ack  = nack;
        m_dval = ndval;
        if (acc) begin
            m_mem[waddr] = wval;
            m_count      = m_count + 16'd1;
        end
        #1;
        if (chk) begin
            check_value("debug_ack", {31'd0, dack}, {31'd0, m_ack});
            check_value("debug_value", dval, m_dval);
            check_value("write_count", {16'd0, wcount}, {16'd0, m_count});
        end
    endtask

    task automatic idle_inputs();
        ra1 = 6'd0; ra2 = 6'd0; waddr = 6'd0; daddr = 6'd0;
        wval = 32'd0; we = 1'b0; dreq = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        ra1 = 6'd5;
        ra2 = 6'd63;
        model_clear();
        #1;
        check_value("rst_ack", {31'd0, dack}, 32'd0);
        check_value("rst_count", {16'd0, wcount}, 32'd0);
        @(posedge clock);
        #1;
        check_value("rst_dval", dval, 32'd0);
        check_value("rst_rd1", rv1, 32'd0);
        check_value("rst_rd2", rv2, 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_clear();
        #2;
        do_reset();

        // Write then read back on port 1
        we = 1'b1; waddr = 6'd5; wval = 32'h1234_5678;
        step(1);
        we = 1'b0; ra1 = 6'd5;
        step(1);
        check_value("first_write_rd1", rv1, 32'h1234_5678);
        check_value("first_write_count", {16'd0, wcount}, 32'd1);

        // Write to entry 0 is dropped
        we = 1'b1; waddr = 6'd0; wval = 32'hFFFF_FFFF; ra1 = 6'd0; ra2 = 6'd0;
        step(1);
        we = 1'b0;
        step(1);
        check_value("addr0_count", {16'd0, wcount}, 32'd1);

        // Same-cycle read of the address being written
        we = 1'b1; waddr = 6'd7; wval = 32'hA5A5_A5A5; ra2 = 6'd7;
        #1;
`ifdef REGISTER_FILE_BYPASS_EN
        check_value("same_cycle_rd2", rv2, 32'hA5A5_A5A5);
`else
        check_value("same_cycle_rd2", rv2, 32'd0);
`endif
        step(1);
        we = 1'b0;
        step(1);

        // Debug capture collides with a same-edge write
        we = 1'b1; waddr = 6'd5; wval = 32'h11;
        step(1);
        dreq = 1'b1; daddr = 6'd5; wval = 32'h22;
        step(1);
        check_value("dbg_ack_pulse", {31'd0, dack}, 32'd1);
        check_value("dbg_prewrite", dval, 32'h11);
        we = 1'b0; daddr = 6'd3;          // request during ack: ignored
        step(1);
        check_value("dbg_ignored_ack", {31'd0, dack}, 32'd0);
        check_value("dbg_hold", dval, 32'h11);
        dreq = 1'b0;
        step(1);

        // Counter wrap after 65536 accepted writes
        do_reset();
        we = 1'b1; waddr = 6'd3;
        for (int i = 0; i < 65536; i++) begin
            wval = i;
            step(i == 65535);
        end
        check_value("count_wrap", {16'd0, wcount}, 32'd0);
        we = 1'b0;

        // Reset in the middle of a debug response
        we = 1'b1; waddr = 6'd9; wval = 32'h0000_DEAD;
        step(1);
        we = 1'b0; dreq = 1'b1; daddr = 6'd9; ra1 = 6'd9;
        step(1);
        check_value("pre_rst_ack", {31'd0, dack}, 32'd1);
        #2;
        reset = 1'b1;
        we = 1'b1; wval = 32'h1234; dreq = 1'b1;
        model_clear();
        #1;
        check_value("mid_rst_ack", {31'd0, dack}, 32'd0);
        check_value("mid_rst_rd9", rv1, 32'd0);
        check_value("mid_rst_count", {16'd0, wcount}, 32'd0);
        @(posedge clock);
        #1;
        check_value("rst_hold_ack", {31'd0, dack}, 32'd0);
        check_value("rst_hold_count", {16'd0, wcount}, 32'd0);
        check_value("rst_hold_rd9", rv1, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        idle_inputs();
        ra1 = 6'd9;
        step(1);

        // Randomized traffic over a small address window to force collisions
        for (int n = 0; n < 400; n++) begin
            ra1   = 6'($urandom_range(0, 15));
            ra2   = (($urandom_range(0, 3)) == 0) ? ra1 : 6'($urandom_range(0, 15));
            waddr = 6'($urandom_range(0, 15));
            wval  = $urandom;
            we    = 1'($urandom_range(0, 1));
            dreq  = 1'($urandom_range(0, 1));
            daddr = 6'($urandom_range(0, 15));
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
